// File: rtl/fp_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fp_pkg
//  Purpose  : Shared types and constants for the FP8 dot-product datapath
//             (sequencer state encoding, FP8 E5M2 / FP32 field widths).
//  Revision : 1.0  initial release
// ============================================================================
package fp_pkg;

   // Dot-product sequencer states
   typedef enum logic [1:0] {
      ACC  = 2'd0,
      WAIT = 2'd1,
      OUT  = 2'd2
   } seq_state_t;

   localparam logic [31:0] FP32_ZERO = 32'h0000_0000;

   // FP8 E5M2 field widths (bias 15)
   localparam int FP8_EXP_W  = 5;
   localparam int FP8_MAN_W  = 2;

   // FP32 field widths
   localparam int FP32_EXP_W = 8;
   localparam int FP32_MAN_W = 23;

   // True when the word is an FP32 NaN: all-ones exponent, nonzero mantissa
   function automatic logic fp32_is_nan(input logic [31:0] f);
      return (f[FP32_MAN_W +: FP32_EXP_W] == {FP32_EXP_W{1'b1}}) &&
             (f[FP32_MAN_W-1:0] != '0);
   endfunction

endpackage : fp_pkg
`default_nettype wire

// File: rtl/fp8_dot_seq.sv
`default_nettype none
// ============================================================================
//  Module   : fp8_dot_seq
//  Purpose  : Dot-product sequencer around an external FP8xFP8+FP32 MAC.
//             Issues one MAC per operand pair, feeds back the running FP32
//             accumulator, and presents the vector sum on a valid/ready port.
//  Revision : 1.0  initial release
// ============================================================================
module fp8_dot_seq
   import fp_pkg::*;
#(
   parameter int TMO   = 15,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   // operand stream
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [7:0]       in_a,
   input  logic [7:0]       in_b,
   input  logic             in_last,
   // MAC issue side
   output logic             mac_valid,
   output logic [7:0]       mac_a,
   output logic [7:0]       mac_b,
   output logic [31:0]      mac_acc,
   // MAC result side
   input  logic             mac_out_valid,
   input  logic [31:0]      mac_out,
   // vector result
   output logic             res_valid,
   input  logic             res_ready,
   output logic [31:0]      res_data,
   output logic [CNT_W-1:0] res_count,
   output logic             res_nan,
   output logic             err_tmo
);

   // Wide enough to hold the value TMO (always at least one bit)
   localparam int            TW    = $clog2(TMO + 2);
   localparam logic [TW-1:0] TMO_C = TW'(TMO);

   seq_state_t       state_q, state_d;
   logic [31:0]      acc_q,   acc_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;
   logic             last_q,  last_d;
   logic [TW-1:0]    tmo_q,   tmo_d;
   logic             err_q,   err_d;

   // State register and datapath flops; reset may hit any state, incl. WAIT
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ACC;
         acc_q   <= FP32_ZERO;
         cnt_q   <= '0;
         last_q  <= 1'b0;
         tmo_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         last_q  <= last_d;
         tmo_q   <= tmo_d;
         err_q   <= err_d;
      end
   end

   // Next-state and handshake decode; MAC strobes outside WAIT are ignored
   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      last_d    = last_q;
      tmo_d     = tmo_q;
      err_d     = err_q;
      in_ready  = 1'b0;
      mac_valid = 1'b0;
      res_valid = 1'b0;

      case (state_q)
         ACC: begin
            in_ready = 1'b1;
            if (in_valid) begin
               mac_valid = 1'b1;
               last_d    = in_last;
               tmo_d     = '0;
               state_d   = WAIT;
            end
         end

         WAIT: begin
            if (mac_out_valid) begin
               acc_d = mac_out;
               if (cnt_q != {CNT_W{1'b1}}) begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
               state_d = last_q ? OUT : ACC;
            end else if (tmo_q == TMO_C) begin
               // MAC never answered: drop the element, keep the running sum
               err_d   = 1'b1;
               state_d = last_q ? OUT : ACC;
            end else begin
               tmo_d = tmo_q + TW'(1);
            end
         end

         OUT: begin
            res_valid = 1'b1;
            if (res_ready) begin
               acc_d   = FP32_ZERO;
               cnt_d   = '0;
               state_d = ACC;
            end
         end

         default: begin
            state_d = ACC;
         end
      endcase
   end

   // Operands pass straight through; only meaningful while mac_valid is high
   assign mac_a     = in_a;
   assign mac_b     = in_b;
   assign mac_acc   = acc_q;

   assign res_data  = acc_q;
   assign res_count = cnt_q;
   assign res_nan   = fp32_is_nan(acc_q);
   assign err_tmo   = err_q;

endmodule : fp8_dot_seq
`default_nettype wire

// File: tb/tb_fp8_dot_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fp8_dot_seq
//  Purpose  : Directed self-checking bench for fp8_dot_seq with a 1-cycle
//             behavioural MAC stub and a result scoreboard.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fp8_dot_seq;

   localparam int CNT_W = 16;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid, in_ready, in_last;
   logic [7:0]       in_a, in_b;
   logic             mac_valid;
   logic [7:0]       mac_a, mac_b;
   logic [31:0]      mac_acc;
   logic             mac_out_valid;
   logic [31:0]      mac_out;
   logic             res_valid, res_ready, res_nan, err_tmo;
   logic [31:0]      res_data;
   logic [CNT_W-1:0] res_count;

   // MAC stub controls
   logic        withhold = 1'b0;
   logic        force_v  = 1'b0;
   logic [31:0] force_data = 32'h0;
   logic        stub_v;
   logic [31:0] stub_d;

   typedef struct {
      logic [31:0]      d;
      logic [CNT_W-1:0] c;
      logic             n;
   } exp_t;
   exp_t sb[$];

   int n_pass = 0;
   int n_tot  = 0;

   fp8_dot_seq #(.TMO(15), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_last(in_last),
      .mac_valid(mac_valid), .mac_a(mac_a), .mac_b(mac_b), .mac_acc(mac_acc),
      .mac_out_valid(mac_out_valid), .mac_out(mac_out),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
      .res_count(res_count), .res_nan(res_nan), .err_tmo(err_tmo)
   );

   always #5 clk = ~clk;

   // ---- FP helpers for the MAC stub --------------------------------------
   function automatic real fp8_to_real(input logic [7:0] x);
      int  e;
      real v;
      e = int'(x[6:2]);
      v = real'(int'(x[1:0])) / 4.0;
      if (e == 0) e = 1;
      else        v = v + 1.0;
      if (e >= 15) for (int i = 0; i < e - 15; i++) v = v * 2.0;
      else         for (int i = 0; i < 15 - e; i++) v = v / 2.0;
      return x[7] ? -v : v;
   endfunction

   function automatic real fp32_to_real(input logic [31:0] f);
      logic [63:0] b;
      int          e;
      if (f[30:0] == 31'h0) return 0.0;
      e = int'(f[30:23]) - 127 + 1023;
      b = {f[31], e[10:0], f[22:0], 29'h0};
      return $bitstoreal(b);
   endfunction

   function automatic logic [31:0] real_to_fp32(input real r);
      logic [63:0] b;
      int          e;
      if (r == 0.0) return 32'h0;
      b = $realtobits(r);
      e = int'(b[62:52]) - 1023 + 127;
      return {b[63], e[7:0], b[51:29]};
   endfunction

   // Behavioural MAC: fixed 1-cycle latency, can be told to withhold
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         stub_v <= 1'b0;
         stub_d <= 32'h0;
      end else begin
         stub_v <= mac_valid && !withhold;
         stub_d <= real_to_fp32(fp32_to_real(mac_acc) +
                                fp8_to_real(mac_a) * fp8_to_real(mac_b));
      end
   end

   assign mac_out_valid = stub_v | force_v;
   assign mac_out       = force_v ? force_data : stub_d;

   // ---- checking -----------------------------------------------------------
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tot++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic push_exp(input logic [31:0] d, input int c, input logic n);
      exp_t e;
      e.d = d;
      e.c = CNT_W'(c);
      e.n = n;
      sb.push_back(e);
   endtask

   // Present one pair, wait (bounded) for acceptance, check the MAC issue
   task automatic send_pair(input string tag, input logic [7:0] a, input logic [7:0] b,
                            input logic last, input logic [31:0] exp_acc);
      int k;
      @(posedge clk); #1;
      in_valid = 1'b1; in_a = a; in_b = b; in_last = last;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!in_ready && k < 20);
      if (!in_ready) begin
         chk({tag, "_accept_timeout"}, 32'(in_ready), 32'h1);
         in_valid = 1'b0;
         return;
      end
      chk({tag, "_mac_valid"}, 32'(mac_valid), 32'h1);
      chk({tag, "_mac_ab"}, {16'h0, mac_a, mac_b}, {16'h0, a, b});
      chk({tag, "_mac_acc"}, mac_acc, exp_acc);
      @(posedge clk); #1;
      in_valid = 1'b0; in_last = 1'b0;
      @(negedge clk);
      chk({tag, "_ready_low_in_wait"}, 32'(in_ready), 32'h0);
   endtask

   // Wait (bounded) for a result, compare with scoreboard, optionally stall
   task automatic get_result(input string tag, input int hold);
      int   k;
      exp_t e;
      k = 0;
      while (!res_valid && k < 30) begin
         @(negedge clk);
         k++;
      end
      chk({tag, "_res_valid"}, 32'(res_valid), 32'h1);
      if (!res_valid) return;
      if (sb.size() == 0) begin
         chk({tag, "_sb_nonempty"}, 32'h0, 32'h1);
         return;
      end
      e = sb.pop_front();
      chk({tag, "_res_data"}, res_data, e.d);
      chk({tag, "_res_count"}, 32'(res_count), 32'(e.c));
      chk({tag, "_res_nan"}, 32'(res_nan), 32'(e.n));
      chk({tag, "_no_ready_with_valid"}, 32'(in_ready), 32'h0);
      for (int h = 0; h < hold; h++) begin
         in_valid = 1'b1;
         in_a = 8'h3C; in_b = 8'h3C; in_last = 1'b1;
         @(negedge clk);
         chk({tag, "_hold_valid"}, 32'(res_valid), 32'h1);
         chk({tag, "_hold_data"}, res_data, e.d);
         chk({tag, "_hold_in_ready"}, 32'(in_ready), 32'h0);
         chk({tag, "_hold_mac_valid"}, 32'(mac_valid), 32'h0);
      end
      in_valid = 1'b0; in_last = 1'b0;
      res_ready = 1'b1;
      @(posedge clk); #1;
      res_ready = 1'b0;
      @(negedge clk);
      chk({tag, "_post_valid"}, 32'(res_valid), 32'h0);
      chk({tag, "_post_in_ready"}, 32'(in_ready), 32'h1);
   endtask

   // Hard stop in case the bench itself wedges
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_a = 8'h0; in_b = 8'h0; in_last = 1'b0;
      res_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);

      // reset state
      chk("rst_in_ready",  32'(in_ready),  32'h1);
      chk("rst_res_valid", 32'(res_valid), 32'h0);
      chk("rst_mac_valid", 32'(mac_valid), 32'h0);
      chk("rst_res_data",  res_data,       32'h0);
      chk("rst_res_count", 32'(res_count), 32'h0);
      chk("rst_res_nan",   32'(res_nan),   32'h0);
      chk("rst_err_tmo",   32'(err_tmo),   32'h0);

      // accumulate three ones
      push_exp(32'h4040_0000, 3, 1'b0);
      send_pair("ones0", 8'h3C, 8'h3C, 1'b0, 32'h0000_0000);
      send_pair("ones1", 8'h3C, 8'h3C, 1'b0, 32'h3F80_0000);
      send_pair("ones2", 8'h3C, 8'h3C, 1'b1, 32'h4000_0000);
      get_result("ones", 0);

      // single element, result two cycles after accept
      push_exp(32'h4080_0000, 1, 1'b0);
      send_pair("single", 8'h40, 8'h40, 1'b1, 32'h0000_0000);
      chk("single_t1_no_res", 32'(res_valid), 32'h0);
      @(negedge clk);
      chk("single_t2_res", 32'(res_valid), 32'h1);
      get_result("single", 0);

      // sign, then accumulator must start from zero again
      push_exp(32'hBF80_0000, 1, 1'b0);
      send_pair("neg", 8'h3C, 8'hBC, 1'b1, 32'h0000_0000);
      get_result("neg", 0);
      push_exp(32'h3F80_0000, 1, 1'b0);
      send_pair("after_neg", 8'h3C, 8'h3C, 1'b1, 32'h0000_0000);
      get_result("after_neg", 0);

      // result backpressure
      push_exp(32'h4080_0000, 1, 1'b0);
      send_pair("bp", 8'h40, 8'h40, 1'b1, 32'h0000_0000);
      get_result("bp", 5);

      // timeout on the second of three elements
      push_exp(32'h4000_0000, 2, 1'b0);
      send_pair("tmo0", 8'h3C, 8'h3C, 1'b0, 32'h0000_0000);
      withhold = 1'b1;
      send_pair("tmo1", 8'h3C, 8'h3C, 1'b0, 32'h3F80_0000);
      repeat (15) @(negedge clk);
      chk("tmo_still_wait", 32'(in_ready), 32'h0);
      chk("tmo_err_not_yet", 32'(err_tmo), 32'h0);
      @(negedge clk);
      chk("tmo_back_in_acc", 32'(in_ready), 32'h1);
      chk("tmo_err_set", 32'(err_tmo), 32'h1);
      withhold = 1'b0;
      send_pair("tmo2", 8'h3C, 8'h3C, 1'b1, 32'h3F80_0000);
      get_result("tmo", 0);
      chk("tmo_err_sticky", 32'(err_tmo), 32'h1);

      // late MAC answer (within the timeout) carrying a NaN
      push_exp(32'h7FC0_0000, 1, 1'b1);
      withhold = 1'b1;
      send_pair("nan", 8'h3C, 8'h3C, 1'b1, 32'h0000_0000);
      force_v = 1'b1; force_data = 32'h7FC0_0000;
      @(posedge clk); #1;
      force_v = 1'b0;
      withhold = 1'b0;
      get_result("nan", 0);

      // reset while waiting on the MAC, stray strobes afterwards
      send_pair("rw0", 8'h3C, 8'h3C, 1'b0, 32'h0000_0000);
      withhold = 1'b1;
      send_pair("rw1", 8'h3C, 8'h3C, 1'b0, 32'h3F80_0000);
      rst = 1'b1;
      #1;
      chk("rw_async_acc", mac_acc, 32'h0);
      chk("rw_async_ready", 32'(in_ready), 32'h1);
      chk("rw_err_cleared", 32'(err_tmo), 32'h0);
      force_v = 1'b1; force_data = 32'h4040_0000;
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      force_v = 1'b0;
      withhold = 1'b0;
      @(negedge clk);
      chk("rw_acc_zero", mac_acc, 32'h0);
      chk("rw_in_ready", 32'(in_ready), 32'h1);
      chk("rw_res_valid", 32'(res_valid), 32'h0);
      push_exp(32'h3F80_0000, 1, 1'b0);
      send_pair("rw2", 8'h3C, 8'h3C, 1'b1, 32'h0000_0000);
      get_result("rw", 0);

      chk("sb_empty", 32'(sb.size()), 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule : tb_fp8_dot_seq
`default_nettype wire

// File: doc/fp8_dot_seq.md
# fp8_dot_seq

Sequencer for dot products, placed around the FP8×FP8+FP32 multiply-accumulate stage. It accepts a valid/ready stream of FP8 (E5M2, bias 15) operand pairs, with `in_last` delimiting vectors. For each pair it issues one MAC operation, feeding back the running FP32 accumulator, and captures the MAC result. At the end of each vector it presents the final FP32 sum on a valid/ready result port.

## Interface
- `TMO`, default 15: cycles to wait in WAIT for `mac_out_valid` before dropping the element.
- `CNT_W`, default 16: width of the element counter.

Ports:
- `clk` in 1: single clock; all state on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: operand pair valid.
- `in_ready` out 1: sequencer can accept a pair.
- `in_a` in 8: FP8 operand A.
- `in_b` in 8: FP8 operand B.
- `in_last` in 1: pair is the final element of the vector.
- `mac_valid` out 1: issue strobe to the MAC (its `input_valid`).
- `mac_a` out 8: MAC operand 1.
- `mac_b` out 8: MAC operand 2.
- `mac_acc` out 32: FP32 accumulator fed to the MAC.
- `mac_out_valid` in 1: MAC result strobe.
- `mac_out` in 32: MAC FP32 result.
- `res_valid` out 1: vector result valid.
- `res_ready` in 1: consumer accepts the result.
- `res_data` out 32: FP32 dot product.
- `res_count` out CNT_W: elements accumulated into `res_data`; saturates at all-ones.
- `res_nan` out 1: `res_data` exponent is 0xFF and mantissa is nonzero.
- `err_tmo` out 1: sticky flag; set when an element is dropped on timeout.

## Operation
- FSM states: ACC, WAIT, OUT. Reset state is ACC.
- ACC:
  - `in_ready`=1.
  - On `in_valid`: `mac_valid`=1 in the same cycle, with `mac_a`=`in_a`, `mac_b`=`in_b`, `mac_acc`=`acc_q` (pass-through, combinational).
  - Latch `last_q`=`in_last`, clear the timeout counter, go to WAIT.
- WAIT:
  - `in_ready`=0, `mac_valid`=0.
  - On `mac_out_valid`: `acc_q`<=`mac_out`, `cnt_q`<=`cnt_q`+1 (saturating). Go to OUT if `last_q`, else ACC.
  - If the timeout counter reaches TMO with no strobe: `err_tmo`<=1, `acc_q` and `cnt_q` unchanged. Go to OUT if `last_q`, else ACC.
- OUT:
  - `res_valid`=1, `res_data`=`acc_q`, `res_count`=`cnt_q`, `in_ready`=0.
  - On `res_ready`: `acc_q`<=32'h0000_0000, `cnt_q`<=0, go to ACC.
- `mac_out_valid` outside WAIT is ignored.
- `mac_a`/`mac_b`/`mac_acc` are don't-care when `mac_valid`=0; drive them from the inputs and `acc_q` regardless.
- The sequencer performs no FP arithmetic. Special values (NaN, Inf) propagate through `acc_q` unchanged; `res_nan` is decoded from `acc_q`.
- `err_tmo` clears only on `rst`.

## Timing
- Reset values:
  - state=ACC, `acc_q`=0, `cnt_q`=0, `last_q`=0, `err_tmo`=0.
  - Outputs after reset: `in_ready`=1, `res_valid`=0, `mac_valid`=0, `res_data`=0, `res_count`=0, `res_nan`=0.
- Handshake: the MAC has a fixed 1-cycle latency.
  - Pair accepted in cycle t → `mac_out_valid` in t+1 → `acc_q` updated at the end of t+1.
  - `in_ready` reasserts in t+2, or `res_valid` asserts in t+2 if the pair was last.
- Throughput: 1 element per 2 cycles.
- Result handshake:
  - `res_valid` stays high and `res_data` stays stable until `res_ready`.
  - `res_valid` and `in_ready` are never high together; the next vector's first pair can be accepted no earlier than the cycle after the result handshake.
- A one-element vector (`in_last` on the first pair) yields `res_count`=1.
- Reset asserted in any state (including mid-WAIT or OUT) returns immediately to ACC with a zero accumulator. A MAC strobe arriving after reset is ignored.
- Timeout: the drop happens in the cycle the counter equals TMO, i.e. TMO+1 cycles after issue.

## Structure
- Shared package `fp_pkg`:
  - State enum `seq_state_t` {ACC, WAIT, OUT}.
  - `FP32_ZERO`=32'h0.
  - FP8 field widths: EXP=5, MAN=2.
  - FP32 field widths: EXP=8, MAN=23.
- Single flat module, no sub-modules. The MAC is external and connects through the `mac_*` ports.

## Test plan
- Accumulate ones: three pairs (0x3C,0x3C), last on the third → `res_data`=0x4040_0000, `res_count`=3, `res_nan`=0; `in_ready` low every other cycle.
- Single element: (0x40,0x40) with `in_last` → `res_valid` two cycles after accept, `res_data`=0x4080_0000, `res_count`=1.
- Sign: (0x3C,0xBC) last → `res_data`=0xBF80_0000. A next vector (0x3C,0x3C) last → 0x3F80_0000, confirming the accumulator cleared.
- Backpressure: hold `res_ready`=0 for 5 cycles → `res_valid` and `res_data` stable, `in_ready`=0, extra `in_valid` not accepted. Raise `res_ready` → ACC next cycle.
- Timeout: MAC stub withholds `mac_out_valid` after the 2nd of 3 pairs (0x3C,0x3C) → after TMO+1 cycles `err_tmo`=1. Result 0x4000_0000 with `res_count`=2; `err_tmo` remains 1.
- Reset mid-WAIT: assert `rst` in the cycle after issue, then deliver `mac_out_valid` → `acc_q` stays 0. Release reset, then (0x3C,0x3C) last → 0x3F80_0000.
